// File: rtl/drone_pkg.sv
// Shared types for the motor drive path.
package drone_pkg;

   localparam int RPM_W = 16;

   typedef logic signed [RPM_W-1:0] rpm_t;

   typedef enum logic [1:0] {
      DISARMED = 2'd0,
      ARMING   = 2'd1,
      RUN      = 2'd2
   } motor_state_e;

endpackage

// File: rtl/rpm_slew_limiter.sv
// Clamps a signed setpoint to 0..RPM_MAX and moves the
// current command at most SLEW_STEP towards it.
module rpm_slew_limiter
   import drone_pkg::*;
#(
   parameter int RPM_MAX   = 30000,
   parameter int SLEW_STEP = 256
) (
   input  logic signed [RPM_W-1:0] target,
   input  logic [RPM_W-1:0]        current,
   output logic [RPM_W-1:0]        next
);

   localparam logic [RPM_W-1:0] MAXV = RPM_W'(RPM_MAX);
   localparam logic [RPM_W-1:0] STEP = RPM_W'(SLEW_STEP);

   logic [RPM_W-1:0] tgt;
   logic [RPM_W-1:0] diff;

   always_comb begin
      tgt = $unsigned(target);
      if (target[RPM_W-1]) begin
         tgt = '0;
      end else if ($unsigned(target) > MAXV) begin
         tgt = MAXV;
      end
   end

   always_comb begin
      next = current;
      diff = '0;
      if (tgt > current) begin
         diff = tgt - current;
         next = (diff > STEP) ? current + STEP : tgt;
      end else if (tgt < current) begin
         diff = current - tgt;
         next = (diff > STEP) ? current - STEP : tgt;
      end
   end

endmodule

// File: rtl/rpm_pwm_drv.sv
// ESC-style PWM driver: arming FSM, per-period setpoint
// sampling with slew limit, and flop-decoded PWM output.
module rpm_pwm_drv
   import drone_pkg::*;
#(
   parameter int CNT_W       = 10,
   parameter int RPM_MAX     = 30000,
   parameter int SLEW_STEP   = 256,
   parameter int ARM_PERIODS = 4
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    arm,
   input  logic signed [RPM_W-1:0] rpm_set,
   output logic                    pwm_out,
   output logic [RPM_W-1:0]        rpm_cmd,
   output logic [CNT_W-1:0]        duty,
   output logic                    period_tick,
   output logic [1:0]              state
);

   localparam int AW = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;
   localparam int SHIFT = 15 - CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [AW-1:0] ARM_LAST = AW'(ARM_PERIODS - 1);

   motor_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] duty_q, duty_d;
   logic [RPM_W-1:0] rpm_cmd_q, rpm_cmd_d;
   logic [AW-1:0]    arm_cnt_q, arm_cnt_d;
   logic [RPM_W-1:0] slew_next;
   logic             tick;

   rpm_slew_limiter #(
      .RPM_MAX   (RPM_MAX),
      .SLEW_STEP (SLEW_STEP)
   ) u_slew (
      .target  (rpm_set),
      .current (rpm_cmd_q),
      .next    (slew_next)
   );

   assign tick = (state_q != DISARMED) && (cnt_q == CNT_MAX);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      duty_d    = duty_q;
      rpm_cmd_d = rpm_cmd_q;
      arm_cnt_d = arm_cnt_q;
      if (!arm) begin
         state_d   = DISARMED;
         cnt_d     = '0;
         duty_d    = '0;
         rpm_cmd_d = '0;
         arm_cnt_d = '0;
      end else begin
         unique case (state_q)
            DISARMED: begin
               state_d = ARMING;
               cnt_d   = '0;
            end
            ARMING: begin
               cnt_d     = cnt_q + 1'b1;
               duty_d    = '0;
               rpm_cmd_d = '0;
               if (tick) begin
                  if (arm_cnt_q == ARM_LAST) begin
                     state_d   = RUN;
                     arm_cnt_d = '0;
                  end else begin
                     arm_cnt_d = arm_cnt_q + 1'b1;
                  end
               end
            end
            RUN: begin
               cnt_d = cnt_q + 1'b1;
               // duty only moves on the wrap so a period is never cut
               if (tick) begin
                  rpm_cmd_d = slew_next;
                  duty_d    = CNT_W'(slew_next >> SHIFT);
               end
            end
            default: begin
               state_d   = DISARMED;
               cnt_d     = '0;
               duty_d    = '0;
               rpm_cmd_d = '0;
               arm_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q   <= DISARMED;
         cnt_q     <= '0;
         duty_q    <= '0;
         rpm_cmd_q <= '0;
         arm_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         duty_q    <= duty_d;
         rpm_cmd_q <= rpm_cmd_d;
         arm_cnt_q <= arm_cnt_d;
      end
   end

   assign pwm_out     = (state_q == RUN) && (cnt_q < duty_q);
   assign rpm_cmd     = rpm_cmd_q;
   assign duty        = duty_q;
   assign period_tick = tick;
   assign state       = state_q;

endmodule
